// File: rtl/rx_gmii_frame_rx.sv
// ============================================================================
// Module   : rx_gmii_frame_rx
// Desc     : GMII receive framer - preamble/SFD strip, DA filter, length limit,
//            byte-buffer write and end-of-frame status.
//            Define RX_CRC_CHECK_EN to enable the CRC-32 FCS check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_gmii_frame_rx #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int          MAX_LEN  = 1518
) (
  input  logic        RX_CLK,
  input  logic        rst,
  input  logic        RX_DV,
  input  logic [7:0]  RXD,
  input  logic        RX_ER,
  output logic        rx_data_v,
  output logic [7:0]  rx_data,
  output logic [10:0] rx_addr,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        frame_err,
  output logic        crc_ok
);

  localparam logic [10:0] c_max_len = 11'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_DROP     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state;
  logic [10:0] r_cnt;
  logic        r_uc_match;
  logic        r_bc_match;
  logic        r_er_seen;

  logic [7:0]  w_mac_byte;
  logic        w_in_da;
  logic        w_uc_match;
  logic        w_bc_match;
  logic        w_filter_fail;
  logic        w_short;
  logic        w_crc_ok;

  always_comb begin
    w_mac_byte = MAC_ADDR[47:40];
    case (r_cnt[2:0])
      3'd1:    w_mac_byte = MAC_ADDR[39:32];
      3'd2:    w_mac_byte = MAC_ADDR[31:24];
      3'd3:    w_mac_byte = MAC_ADDR[23:16];
      3'd4:    w_mac_byte = MAC_ADDR[15:8];
      3'd5:    w_mac_byte = MAC_ADDR[7:0];
      default: w_mac_byte = MAC_ADDR[47:40];
    endcase
  end

  // Match flags accumulate over DA bytes; a frame is dropped once neither survives.
  assign w_in_da       = (r_cnt < 11'd6);
  assign w_uc_match    = r_uc_match & (~w_in_da | (RXD == w_mac_byte));
  assign w_bc_match    = r_bc_match & (~w_in_da | (RXD == 8'hFF));
  assign w_filter_fail = w_in_da & ~w_uc_match & ~w_bc_match;
  assign w_short       = (r_cnt < 11'd64);

`ifdef RX_CRC_CHECK_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_rev;

  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // The register runs LSB-first; bit-reverse it to compare with the MSB-first residue.
  always_comb begin
    w_crc_rev = '0;
    for (int i = 0; i < 32; i++) begin
      w_crc_rev[i] = r_crc[31-i];
    end
  end

  assign w_crc_ok = (w_crc_rev == 32'hC704DD7B);
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_uc_match <= 1'b0;
      r_bc_match <= 1'b0;
      r_er_seen  <= 1'b0;
      rx_data_v  <= 1'b0;
      rx_data    <= '0;
      rx_addr    <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      crc_ok     <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      r_crc      <= 32'hFFFFFFFF;
`endif
    end else begin
      rx_data_v  <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RX_DV && (RXD == 8'h55)) r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          if (!RX_DV) begin
            r_state <= S_IDLE;
          end else if (RXD == 8'hD5) begin
            r_state    <= S_DATA;
            r_cnt      <= '0;
            r_uc_match <= 1'b1;
            r_bc_match <= 1'b1;
            r_er_seen  <= 1'b0;
`ifdef RX_CRC_CHECK_EN
            r_crc      <= 32'hFFFFFFFF;
`endif
          end else if (RXD != 8'h55) begin
            r_state <= S_DROP;
          end
        end
        S_DATA: begin
          if (!RX_DV) begin
            r_state    <= S_DONE;
            frame_done <= 1'b1;
            frame_len  <= r_cnt;
            frame_err  <= r_er_seen | w_short | ~w_crc_ok;
            crc_ok     <= w_crc_ok;
          end else if ((r_cnt == c_max_len) || w_filter_fail) begin
            r_state <= S_DROP;
          end else begin
            rx_data_v  <= 1'b1;
            rx_data    <= RXD;
            rx_addr    <= r_cnt;
            r_cnt      <= r_cnt + 11'd1;
            r_uc_match <= w_uc_match;
            r_bc_match <= w_bc_match;
            if (RX_ER) r_er_seen <= 1'b1;
`ifdef RX_CRC_CHECK_EN
            r_crc      <= f_crc_byte(r_crc, RXD);
`endif
          end
        end
        S_DROP: begin
          if (!RX_DV) r_state <= S_IDLE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
